accel_counter: RTL and testbench
================================

# accel_counter

Parametrised accelerating up/down counter for front-panel value entry: counts on an internally generated tick, starts with step 1 and doubles its step after a configurable run of same-direction ticks, saturates at 0 and 2^WIDTH-1, and accepts a synchronous preload. It replaces derived slow clocks with a single-clock tick enable and sits between debounced switch inputs and display/register logic.

## Interface

- WIDTH, 16: counter width in bits.
- DIV, 12500000: tick period in clk cycles; must be at least 1.
- THRESH, 15: ticks spent at one step level before the step doubles; must be at least 1.
- MAX_SHIFT, 1: highest step level; the step is 1<<lvl. MAX_SHIFT must be less than WIDTH.
- clk  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable, sampled every clk.
- up  input  1  direction: 1 counts up, 0 counts down; sampled on tick cycles.
- load  input  1  synchronous preload strobe.
- din  input  WIDTH  preload value.
- dout  output  WIDTH  counter value, registered.
- tick  output  1  one-cycle registered tick pulse.
- lvl  output  clog2(MAX_SHIFT+1)  current step level, registered.
- at_limit  output  1  registered; high while in LIMIT.

## Operation

- Reset values: dout=0, tick=0, lvl=0, at_limit=0, run_cnt=0, tick_cnt=0, last_dir=1, state IDLE.
- Tick generator:
  - tick_cnt runs 0..DIV-1 freely and is cleared only by rst.
  - Each edge sets tick <= (tick_cnt==DIV-1).
  - DIV=1 gives tick=1 on every cycle after the first edge.
- Priority at each clk edge, highest first:
  - load: dout<=din, run_cnt<=0, lvl<=0, state IDLE. This applies regardless of en or tick.
  - en=0: run_cnt<=0, lvl<=0, state IDLE, dout held.
  - tick=1 with en=1: a counting step, below.
  - Otherwise hold everything.
- Counting step, where s = 1<<lvl:
  - From IDLE, or when up differs from last_dir: the step is 1, run_cnt<=1, lvl<=0, last_dir<=up, state COUNT.
  - In COUNT with the same direction: the step is s and run_cnt increments. When the incremented run_cnt reaches THRESH and lvl<MAX_SHIFT, lvl increments and run_cnt<=0. At lvl==MAX_SHIFT, run_cnt saturates at THRESH.
  - Up: if dout > 2^WIDTH-1-step then dout<=2^WIDTH-1, else dout+step.
  - Down: if dout < step then dout<=0, else dout-step.
  - If the result equals the bound in the direction of travel, state becomes LIMIT.
- LIMIT state:
  - A tick in the same direction holds dout, lvl and run_cnt.
  - A tick in the opposite direction takes a step of 1 and applies the direction-change rule.
  - en=0 or load leaves LIMIT.
- State encoding: IDLE, COUNT, LIMIT. The encoding is free; at_limit is high in LIMIT only.
- With default parameters, ticks 1..15 step 1 and ticks 16 onward step 2.

## Timing

- tick goes high in the cycle after the edge where tick_cnt==DIV-1.
- dout and lvl update on the edge that samples tick=1, so they are visible one cycle after the tick pulse.
- After rst release with DIV=4: tick is high following edge 4, and dout first changes at edge 5.
- load and the effect of en=0 take effect on the next clk edge; they are not tick-qualified.
- Asserting rst mid-run clears all state immediately, with no clk required.

## Configuration

- ACCEL_WRAP_EN defined:
  - Arithmetic is modulo 2^WIDTH and LIMIT is never entered.
  - at_limit becomes a one-cycle pulse on the edge where dout wraps (max→0 up, 0→max down).
  - Step level and run logic are unchanged across a wrap.
- ACCEL_WRAP_EN undefined: saturating behaviour as above.

## Test plan

All scenarios use WIDTH=8, DIV=4, THRESH=3, MAX_SHIFT=2.

- Acceleration: reset, then en=1, up=1 → dout per tick 1,2,3,5,7,9,13,17,21,25. lvl is 0,0,0,1,1,1,2,2,2,2. dout first changes at edge 5.
- Up saturation: load din=250, up=1 → per tick 251,252,253,255. at_limit=1 from the edge producing 255. Further ticks hold 255.
- Down saturation and reversal: load din=1, up=0 → 0 with at_limit=1. Then up=1 → 1, at_limit=0, lvl=0.
- Reversal at speed: reach lvl=2 counting up at dout=13, then set up=0 → next tick gives 12, lvl=0, run restarts.
- en drop and load priority:
  - Deassert en for one non-tick cycle at lvl=2 → lvl=0 next edge, dout held. The next step is ±1.
  - Assert load=1 with din=0x40 on a tick edge → dout=0x40, no step applied.
- ACCEL_WRAP_EN: load 254, up=1 → 255, 0, 1. at_limit pulses exactly once, on the 255→0 edge.

Source files
------------

// File: rtl/accel_counter_if.sv
// accel_counter_if: entry controls in, count value and status out.
// master drives en/up/load/din; slave returns dout/tick/lvl/at_limit.
interface accel_counter_if #(
    parameter int WIDTH     = 16,
    parameter int MAX_SHIFT = 1
);
    localparam int LW = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             tick;
    logic [LW-1:0]    lvl;
    logic             at_limit;

    modport master (
        output en, up, load, din,
        input  dout, tick, lvl, at_limit
    );

    modport slave (
        input  en, up, load, din,
        output dout, tick, lvl, at_limit
    );
endinterface

// File: rtl/accel_counter.sv
// accel_counter: accelerating up/down counter stepping on an internal tick.
// Saturates at 0/max; define ACCEL_WRAP_EN for modulo counting with wrap pulse.
module accel_counter #(
    parameter int WIDTH     = 16,
    parameter int DIV       = 12500000,
    parameter int THRESH    = 15,
    parameter int MAX_SHIFT = 1
) (
    input  logic clk,
    input  logic rst,
    accel_counter_if.slave io
);
    localparam int LW = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(THRESH + 1);

    typedef enum logic [1:0] {IDLE, COUNT, LIMIT} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tick_cnt_q;
    logic             tick_q;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [RW-1:0]    run_q, run_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             dir_q, dir_d;
    logic             at_limit_q, at_limit_d;

    logic             tick_wrap;
    logic             fresh;
    logic             moves;
    logic [WIDTH-1:0] step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt;

    assign tick_wrap = (tick_cnt_q == TW'(DIV - 1));

    // A direction change or a start from rest always restarts at step 1.
    assign fresh = (state_q == IDLE) || (io.up != dir_q);
    assign moves = io.tick && io.en && !io.load && (fresh || state_q == COUNT);
    assign step  = fresh ? WIDTH'(1) : (WIDTH'(1) << lvl_q);

    // Top bit is carry when adding, borrow when subtracting.
    assign sum = io.up ? ({1'b0, dout_q} + {1'b0, step})
                       : ({1'b0, dout_q} - {1'b0, step});

`ifdef ACCEL_WRAP_EN
    assign nxt = sum[WIDTH-1:0];
`else
    assign nxt = sum[WIDTH] ? {WIDTH{io.up}} : sum[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        run_d   = run_q;
        lvl_d   = lvl_q;
        dir_d   = dir_q;
        if (io.load) begin
            dout_d  = io.din;
            run_d   = '0;
            lvl_d   = '0;
            state_d = IDLE;
        end else if (!io.en) begin
            run_d   = '0;
            lvl_d   = '0;
            state_d = IDLE;
        end else if (moves) begin
            dout_d  = nxt;
            state_d = COUNT;
            if (fresh) begin
                run_d = RW'(1);
                lvl_d = '0;
                dir_d = io.up;
            end else if (int'(run_q) + 1 >= THRESH) begin
                if (int'(lvl_q) < MAX_SHIFT) begin
                    lvl_d = lvl_q + LW'(1);
                    run_d = '0;
                end else begin
                    run_d = RW'(THRESH);
                end
            end else begin
                run_d = run_q + RW'(1);
            end
`ifndef ACCEL_WRAP_EN
            if (nxt == {WIDTH{io.up}}) state_d = LIMIT;
`endif
        end
    end

`ifdef ACCEL_WRAP_EN
    assign at_limit_d = moves && sum[WIDTH];
`else
    assign at_limit_d = (state_d == LIMIT);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            dout_q     <= '0;
            run_q      <= '0;
            lvl_q      <= '0;
            dir_q      <= 1'b1;
            state_q    <= IDLE;
            at_limit_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + TW'(1);
            tick_q     <= tick_wrap;
            dout_q     <= dout_d;
            run_q      <= run_d;
            lvl_q      <= lvl_d;
            dir_q      <= dir_d;
            state_q    <= state_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign io.dout     = dout_q;
    assign io.tick     = tick_q;
    assign io.lvl      = lvl_q;
    assign io.at_limit = at_limit_q;
endmodule

// File: tb/tb_accel_counter.sv
// tb_accel_counter: directed vectors plus an arithmetic reference model
// checked every cycle; WIDTH=8, DIV=4, THRESH=3, MAX_SHIFT=2.
module tb_accel_counter;
    localparam int W    = 8;
    localparam int DIV  = 4;
    localparam int TH   = 3;
    localparam int MS   = 2;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_on = 1'b0;

    accel_counter_if #(.WIDTH(W), .MAX_SHIFT(MS)) bus ();

    accel_counter #(
        .WIDTH(W), .DIV(DIV), .THRESH(TH), .MAX_SHIFT(MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: mode 0 rest, 1 counting, 2 pinned at a bound.
    int m_dout = 0, m_lvl = 0, m_run = 0, m_tc = 0, m_mode = 0;
    bit m_tick = 0, m_lim = 0, m_dir = 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_dout = 0; m_lvl = 0; m_run = 0; m_tc = 0;
            m_mode = 0; m_tick = 0; m_lim = 0; m_dir = 1;
        end else begin
            bit t;
            int stp;
            int raw;
            t      = m_tick;
            m_tick = (m_tc == DIV - 1);
            m_tc   = (m_tc + 1) % DIV;
            stp    = 0;
`ifdef ACCEL_WRAP_EN
            m_lim  = 0;
`endif
            if (bus.load) begin
                m_dout = int'(bus.din);
                m_run = 0; m_lvl = 0; m_mode = 0;
            end else if (!bus.en) begin
                m_run = 0; m_lvl = 0; m_mode = 0;
            end else if (t) begin
                if (m_mode == 0 || bus.up != m_dir) begin
                    stp = 1; m_run = 1; m_lvl = 0;
                    m_dir = bus.up; m_mode = 1;
                end else if (m_mode == 1) begin
                    stp = 2 ** m_lvl;
                    m_run++;
                    if (m_run >= TH) begin
                        if (m_lvl < MS) begin m_lvl++; m_run = 0; end
                        else m_run = TH;
                    end
                end
                if (stp > 0) begin
                    raw = bus.up ? m_dout + stp : m_dout - stp;
`ifdef ACCEL_WRAP_EN
                    if (raw > MAXV || raw < 0) m_lim = 1;
                    m_dout = (raw + MAXV + 1) % (MAXV + 1);
`else
                    m_dout = (raw > MAXV) ? MAXV : (raw < 0) ? 0 : raw;
                    if ((bus.up && m_dout == MAXV) || (!bus.up && m_dout == 0))
                        m_mode = 2;
`endif
                end
            end
`ifndef ACCEL_WRAP_EN
            m_lim = (m_mode == 2);
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dout",     int'(bus.dout),     m_dout);
            chk("lvl",      int'(bus.lvl),      m_lvl);
            chk("tick",     int'(bus.tick),     int'(m_tick));
            chk("at_limit", int'(bus.at_limit), int'(m_lim));
        end
    end

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < 40);
        if (!bus.tick) chk("tick_timeout", int'(bus.tick), 1);
    endtask

    // Returns level used for the step and the value after it.
    task automatic step(output int d, output int l);
        int n;
        wait_tick(n);
        l = int'(bus.lvl);
        @(negedge clk);
        d = int'(bus.dout);
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        bus.load = 1'b1;
        bus.din  = W'(v);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    int acc_d[10] = '{1, 2, 3, 5, 7, 9, 13, 17, 21, 25};
    int acc_l[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2};

    initial begin
        int n, d, l;
        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.din = '0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_dout",  int'(bus.dout), 0);
        chk("rst_tick",  int'(bus.tick), 0);
        chk("rst_lvl",   int'(bus.lvl), 0);
        chk("rst_limit", int'(bus.at_limit), 0);

        // acceleration from reset
        bus.en = 1'b1; bus.up = 1'b1; rst = 1'b1;
        wait_tick(n);
        chk("first_tick_edge", n, 4);
        chk("pre_step_dout", int'(bus.dout), 0);
        l = int'(bus.lvl);
        @(negedge clk);
        chk("edge5_dout", int'(bus.dout), acc_d[0]);
        chk("accel_lvl0", l, acc_l[0]);
        for (int i = 1; i < 10; i++) begin
            step(d, l);
            chk("accel_dout", d, acc_d[i]);
            chk("accel_lvl", l, acc_l[i]);
        end

        // reversal at speed
        do_load(0);
        for (int i = 0; i < 7; i++) step(d, l);
        chk("rev_base", d, 13);
        chk("rev_base_lvl", int'(bus.lvl), 2);
        bus.up = 1'b0;
        step(d, l);
        chk("rev_dout", d, 12);
        chk("rev_lvl", int'(bus.lvl), 0);
        for (int i = 0; i < 5; i++) step(d, l);
        chk("down_dout", d, 4);
        chk("down_lvl", int'(bus.lvl), 2);

        // en drop on a non-tick cycle
        bus.en = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
        chk("endrop_lvl", int'(bus.lvl), 0);
        chk("endrop_dout", int'(bus.dout), 4);
        step(d, l);
        chk("endrop_step", d, 3);

        // load wins over a tick
        wait_tick(n);
        bus.load = 1'b1; bus.din = 8'h40;
        @(negedge clk);
        bus.load = 1'b0;
        chk("load_tick", int'(bus.dout), 8'h40);
        step(d, l);
        chk("after_load", d, 8'h3f);

`ifdef ACCEL_WRAP_EN
        bus.up = 1'b1;
        do_load(254);
        step(d, l);
        chk("wrap_255", d, 255);
        chk("wrap_lim0", int'(bus.at_limit), 0);
        step(d, l);
        chk("wrap_0", d, 0);
        chk("wrap_pulse", int'(bus.at_limit), 1);
        @(negedge clk);
        chk("wrap_pulse_end", int'(bus.at_limit), 0);
        step(d, l);
        chk("wrap_1", d, 1);
        chk("wrap_lim1", int'(bus.at_limit), 0);
`else
        bus.up = 1'b1;
        do_load(250);
        step(d, l); chk("sat_251", d, 251);
        step(d, l); chk("sat_252", d, 252);
        step(d, l); chk("sat_253", d, 253);
        chk("sat_lim_pre", int'(bus.at_limit), 0);
        step(d, l); chk("sat_255", d, 255);
        chk("sat_lim", int'(bus.at_limit), 1);
        step(d, l); chk("sat_hold", d, 255);
        step(d, l); chk("sat_hold2", d, 255);
        chk("sat_lim_hold", int'(bus.at_limit), 1);

        bus.up = 1'b0;
        do_load(1);
        chk("load_clears_lim", int'(bus.at_limit), 0);
        step(d, l); chk("sat_zero", d, 0);
        chk("zero_lim", int'(bus.at_limit), 1);
        bus.up = 1'b1;
        step(d, l); chk("leave_zero", d, 1);
        chk("leave_lim", int'(bus.at_limit), 0);
        chk("leave_lvl", int'(bus.lvl), 0);
`endif

        // asynchronous reset mid-run
        step(d, l);
        step(d, l);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_dout", int'(bus.dout), 0);
        chk("async_lvl", int'(bus.lvl), 0);
        chk("async_tick", int'(bus.tick), 0);
        chk("async_lim", int'(bus.at_limit), 0);
        @(negedge clk);
        rst = 1'b1;
        step(d, l);
        chk("post_rst", d, 1);
        step(d, l);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
